// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared definitions for the RV32M multiply/divide unit.
//   - funct3 operation codes
//   - mdu_state_t FSM encoding
//   - operation classification helpers (divide vs multiply, operand signedness)
package rv32m_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   // funct3[2] separates the divide group from the multiply group
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational conditional two's-complement negation.
// Ports:
//   i_neg  - 1: output is -i_val, 0: output is i_val
//   i_val  - input value (WIDTH bits)
//   o_val  - conditionally negated value (WIDTH bits)
module mdu_sign_fix #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             i_neg,
   input  logic [WIDTH-1:0] i_val,
   output logic [WIDTH-1:0] o_val
);

   assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring shift-subtract divide, one step
// per cycle over ITER cycles. Divide-by-zero and signed overflow resolve
// without iterating.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - request, honoured in IDLE or DONE only
//   op        - funct3 operation code
//   rs1_val   - operand A, rs2_val - operand B
//   rd_addr   - destination register, captured with start
//   busy      - high while iterating (CALC)
//   done      - one-cycle pulse, result/rd_out valid (register file WE)
//   result    - registered result, rd_out - destination held with result
module mul_div_unit
   import rv32m_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned ITER          = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [2:0]               op,
   input  logic [DATA_WIDTH-1:0]    rs1_val,
   input  logic [DATA_WIDTH-1:0]    rs2_val,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    result,
   output logic [ADDRESS_WIDTH-1:0] rd_out
);

   localparam int unsigned CNT_W = $clog2(ITER);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   mdu_state_t               r_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [2:0]               r_op;
   logic [ADDRESS_WIDTH-1:0] r_rd;
   logic [DATA_WIDTH-1:0]    r_hi;
   logic [DATA_WIDTH-1:0]    r_lo;
   logic [DATA_WIDTH-1:0]    r_b;
   logic                     r_neg_a;
   logic                     r_neg_b;
   logic [DATA_WIDTH-1:0]    r_result;
   logic [ADDRESS_WIDTH-1:0] r_rd_out;

   logic                      w_neg_a;
   logic                      w_neg_b;
   logic [DATA_WIDTH-1:0]     w_abs_a;
   logic [DATA_WIDTH-1:0]     w_abs_b;
   logic                      w_b_zero;
   logic                      w_ovf;
   logic                      w_special;
   logic [DATA_WIDTH-1:0]     w_special_res;
   logic [DATA_WIDTH:0]       w_sum;
   logic [DATA_WIDTH:0]       w_shift;
   logic [DATA_WIDTH:0]       w_diff;
   logic [DATA_WIDTH-1:0]     w_nhi;
   logic [DATA_WIDTH-1:0]     w_nlo;
   logic [2*DATA_WIDTH-1:0]   w_fix_in;
   logic                      w_fix_neg;
   logic [2*DATA_WIDTH-1:0]   w_fix_out;
   logic [DATA_WIDTH-1:0]     w_final;

   // ---------------- operand magnitudes ----------------
   assign w_neg_a = is_signed_a(op) & rs1_val[DATA_WIDTH-1];
   assign w_neg_b = is_signed_b(op) & rs2_val[DATA_WIDTH-1];

   mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_a (
      .i_neg (w_neg_a),
      .i_val (rs1_val),
      .o_val (w_abs_a)
   );

   mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_b (
      .i_neg (w_neg_b),
      .i_val (rs2_val),
      .o_val (w_abs_b)
   );

   // ---------------- special cases ----------------
   assign w_b_zero  = (rs2_val == '0);
   assign w_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_val == MIN_NEG) && (rs2_val == '1);
   assign w_special = is_div(op) & (w_b_zero | w_ovf);

   // op[1] selects remainder within the divide group
   always_comb begin
      w_special_res = '0;
      if (w_b_zero) begin
         w_special_res = op[1] ? rs1_val : '1;
      end else if (w_ovf) begin
         w_special_res = op[1] ? '0 : MIN_NEG;
      end
   end

   // ---------------- one iteration step ----------------
   // Multiply: {r_hi,r_lo} holds {partial product, remaining multiplier};
   // add |B| when the multiplier LSB is set, then shift the pair right.
   // Divide: {r_hi,r_lo} holds {partial remainder, dividend/quotient};
   // shift left, trial-subtract |B|, keep the difference if non-negative.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_shift = {r_hi, r_lo[DATA_WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_b};
      if (is_div(r_op)) begin
         if (!w_diff[DATA_WIDTH]) begin
            w_nhi = w_diff[DATA_WIDTH-1:0];
            w_nlo = {r_lo[DATA_WIDTH-2:0], 1'b1};
         end else begin
            w_nhi = w_shift[DATA_WIDTH-1:0];
            w_nlo = {r_lo[DATA_WIDTH-2:0], 1'b0};
         end
      end else begin
         w_nhi = w_sum[DATA_WIDTH:1];
         w_nlo = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
      end
   end

   // ---------------- final sign correction ----------------
   // One shared negator: the product, the quotient or the remainder is
   // routed through it depending on the operation.
   always_comb begin
      if (is_div(r_op)) begin
         w_fix_in  = {{DATA_WIDTH{1'b0}}, (r_op[1] ? w_nhi : w_nlo)};
         w_fix_neg = r_op[1] ? r_neg_a : (r_neg_a ^ r_neg_b);
      end else begin
         w_fix_in  = {w_nhi, w_nlo};
         w_fix_neg = r_neg_a ^ r_neg_b;
      end
   end

   mdu_sign_fix #(.WIDTH(2*DATA_WIDTH)) u_fix (
      .i_neg (w_fix_neg),
      .i_val (w_fix_in),
      .o_val (w_fix_out)
   );

   assign w_final = (is_div(r_op) || (r_op == OP_MUL)) ?
                    w_fix_out[DATA_WIDTH-1:0] : w_fix_out[2*DATA_WIDTH-1:DATA_WIDTH];

   // ---------------- FSM and datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_rd     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
         r_neg_a  <= 1'b0;
         r_neg_b  <= 1'b0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_op    <= op;
                  r_rd    <= rd_addr;
                  r_neg_a <= w_neg_a;
                  r_neg_b <= w_neg_b;
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_rd_out <= rd_addr;
                     r_state  <= DONE;
                  end else begin
                     r_hi    <= '0;
                     r_lo    <= w_abs_a;
                     r_b     <= w_abs_b;
                     r_cnt   <= '0;
                     r_state <= CALC;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            CALC: begin
               r_hi  <= w_nhi;
               r_lo  <= w_nlo;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(ITER-1)) begin
                  r_result <= w_final;
                  r_rd_out <= r_rd;
                  r_state  <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy   = (r_state == CALC);
   assign done   = (r_state == DONE);
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit. Stimulus pushes the
// hand-computed result, destination and completion cycle; a monitor pops
// and compares on every done pulse.
module tb_mul_div_unit;
   import rv32m_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic [4:0]  rd_addr = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   mul_div_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .ITER(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .rd_out  (rd_out)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int unsigned due;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pulse", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_rd"}, {27'd0, rd_out}, {27'd0, e.rd});
            chk({e.name, "_cycle"}, cyc, e.due);
         end
      end
   end

   // called at a negedge; the following posedge samples start
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int unsigned lat, input string name);
      exp_t e;
      op      = o;
      rs1_val = a;
      rs2_val = b;
      rd_addr = rd;
      start   = 1'b1;
      e.res  = exp;
      e.rd   = rd;
      e.due  = cyc + lat;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending, expected 0", name, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic expect_idle(input string name);
      chk({name, "_busy"},   {31'd0, busy}, 32'd0);
      chk({name, "_done"},   {31'd0, done}, 32'd0);
      chk({name, "_result"}, result, 32'd0);
      chk({name, "_rd_out"}, {27'd0, rd_out}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;
      repeat (3) @(negedge clk);
      expect_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      expect_idle("idle");

      // multiply group
      issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, "mul_7_m3");
      wait_idle("mul_7_m3");
      issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 33, "mulhu");
      wait_idle("mulhu");
      issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 33, "mulh");
      wait_idle("mulh");
      issue(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF, 33, "mulhsu");
      wait_idle("mulhsu");
      issue(OP_MUL,    32'd3,        32'd4,        5'd0,  32'd12,       33, "mul_x0");
      wait_idle("mul_x0");

      // divide group
      issue(OP_DIV,  32'hFFFFFFF9, 32'd2, 5'd7,  32'hFFFFFFFD, 33, "div_m7_2");
      wait_idle("div_m7_2");
      issue(OP_REM,  32'hFFFFFFF9, 32'd2, 5'd8,  32'hFFFFFFFF, 33, "rem_m7_2");
      wait_idle("rem_m7_2");
      issue(OP_DIVU, 32'd100,      32'd7, 5'd10, 32'd14,       33, "divu_100_7");
      wait_idle("divu_100_7");
      issue(OP_REMU, 32'd100,      32'd7, 5'd11, 32'd2,        33, "remu_100_7");
      wait_idle("remu_100_7");

      // special cases: single-cycle
      issue(OP_DIV,  32'd20,       32'd0,        5'd12, 32'hFFFFFFFF, 1, "div_by0");
      wait_idle("div_by0");
      issue(OP_REMU, 32'd20,       32'd0,        5'd13, 32'd20,       1, "remu_by0");
      wait_idle("remu_by0");
      issue(OP_DIVU, 32'd20,       32'd0,        5'd14, 32'hFFFFFFFF, 1, "divu_by0");
      wait_idle("divu_by0");
      issue(OP_REM,  32'hFFFFFFEC, 32'd0,        5'd15, 32'hFFFFFFEC, 1, "rem_by0");
      wait_idle("rem_by0");
      issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1, "div_ovf");
      wait_idle("div_ovf");
      issue(OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h00000000, 1, "rem_ovf");
      wait_idle("rem_ovf");

      // start during CALC is ignored
      issue(OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33, "ignore_start");
      repeat (4) @(negedge clk);
      chk("calc_busy", {31'd0, busy}, 32'd1);
      op      = OP_MUL;
      rs1_val = 32'd2;
      rs2_val = 32'd3;
      rd_addr = 5'd3;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("ignore_start");

      // back-to-back: new start in the DONE cycle
      issue(OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 33, "b2b_first");
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("b2b_done_seen", {31'd0, seen}, 32'd1);
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 33, "b2b_second");
      wait_idle("b2b_second");

      // reset aborts an operation at iteration 10
      op      = OP_MUL;
      rs1_val = 32'd7;
      rs2_val = 32'hFFFFFFFD;
      rd_addr = 5'd5;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      expect_idle("abort");
      rst = 1'b0;
      repeat (40) @(negedge clk);
      expect_idle("post_abort");

      issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, "after_reset");
      wait_idle("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
